tfe_feature_scheduler: RTL and testbench

TFE_FEATURE_SCHEDULER -- requirements
Module: tfe_feature_scheduler

---
 rtl/tfe_pkg.sv | 24 ++
 rtl/tfe_feature_scheduler_if.sv | 22 ++
 rtl/tfe_tag_delay.sv | 31 +++
 rtl/tfe_feature_scheduler.sv | 135 +++++++++++++
 tb/tb_tfe_feature_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tfe_pkg.sv
// Shared types and constants for the feature scheduler and its tag alignment chain.
package tfe_pkg;

    localparam int FEAT_W   = 256;
    localparam int REQ_ID_W = 1;
    localparam int CNT_W    = 8;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ0 = req_id_t'(0);
    localparam req_id_t REQ1 = req_id_t'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Sideband that travels alongside each issued word.
    typedef struct packed {
        req_id_t src;
        logic    last;
    } tag_t;

endpackage

// File: rtl/tfe_feature_scheduler_if.sv
// Requester-side valid/ready handshake for both feature sources.
interface tfe_feature_scheduler_if;
    import tfe_pkg::*;

    logic              i_req0_valid;
    logic [FEAT_W-1:0] i_req0_feature;
    logic              o_req0_ready;
    logic              i_req1_valid;
    logic [FEAT_W-1:0] i_req1_feature;
    logic              o_req1_ready;

    modport master (
        output i_req0_valid, i_req0_feature, i_req1_valid, i_req1_feature,
        input  o_req0_ready, o_req1_ready
    );

    modport slave (
        input  i_req0_valid, i_req0_feature, i_req1_valid, i_req1_feature,
        output o_req0_ready, o_req1_ready
    );

endinterface

// File: rtl/tfe_tag_delay.sv
// Fixed-depth shift register that delays a tag by DEPTH cycles; advances every cycle.
module tfe_tag_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is cleared on reset (not just the head) so no stale tag drains out afterwards;
    // non-blocking assignments let each stage sample its neighbour's old value in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tfe_feature_scheduler.sv
// Two-requester round-robin burst scheduler feeding the preprocess stage.
// Registers each accepted word and aligns its source/last tag with the preprocess latency.
module tfe_feature_scheduler
    import tfe_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int PP_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    tfe_feature_scheduler_if.slave req_if,
    output logic [FEAT_W-1:0]      o_feature,
    output logic                   o_feature_valid,
    output logic                   o_pp_src,
    output logic                   o_pp_last,
    output logic                   o_busy,
    output logic                   o_burst_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_e            state_q, state_d;
    req_id_t           grant_q, grant_d;
    req_id_t           ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [FEAT_W-1:0] feature_q, feature_d;
    logic              feature_valid_q;
    tag_t              tag_q, tag_d;
    tag_t              pp_tag;

    logic              ready0, ready1;
    logic              xfer, is_last;
    logic              gnt_valid;
    logic [FEAT_W-1:0] gnt_feature;

    assign gnt_valid   = (grant_q == REQ0) ? req_if.i_req0_valid   : req_if.i_req1_valid;
    assign gnt_feature = (grant_q == REQ0) ? req_if.i_req0_feature : req_if.i_req1_feature;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        xfer    = 1'b0;
        is_last = 1'b0;
        ready0  = 1'b0;
        ready1  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_flush && (req_if.i_req0_valid || req_if.i_req1_valid)) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                    grant_d = (req_if.i_req0_valid && req_if.i_req1_valid)
                              ? ptr_q : req_id_t'(req_if.i_req1_valid);
                end
            end
            ST_BURST: begin
                if (i_flush) begin
                    // Abort: pointer is left alone so the same requester wins again.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    ready0 = (grant_q == REQ0);
                    ready1 = (grant_q == REQ1);
                    xfer   = gnt_valid;
                    if (xfer) begin
                        if (cnt_q == LAST_CNT) begin
                            is_last = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            ptr_d   = ~grant_q;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        feature_d    = xfer ? gnt_feature : feature_q;
        tag_d.src    = xfer ? grant_q : REQ0;
        tag_d.last   = is_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= REQ0;
            ptr_q           <= REQ0;
            cnt_q           <= '0;
            done_q          <= 1'b0;
            feature_q       <= '0;
            feature_valid_q <= 1'b0;
            tag_q           <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            done_q          <= done_d;
            feature_q       <= feature_d;
            feature_valid_q <= xfer;
            tag_q           <= tag_d;
        end
    end

    tfe_tag_delay #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (PP_LAT)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tag_q),
        .q_o   (pp_tag)
    );

    assign req_if.o_req0_ready = ready0;
    assign req_if.o_req1_ready = ready1;
    assign o_feature           = feature_q;
    assign o_feature_valid     = feature_valid_q;
    assign o_pp_src            = pp_tag.src;
    assign o_pp_last           = pp_tag.last;
    assign o_busy              = (state_q == ST_BURST);
    assign o_burst_done        = done_q;

endmodule

// File: tb/tb_tfe_feature_scheduler.sv
// Bench for tfe_feature_scheduler: directed scenarios plus a randomized run
// against a word-counting reference model, on a BURST_LEN=4/PP_LAT=3 and a BURST_LEN=1/PP_LAT=1 instance.
`timescale 1ns/1ps
module tb_tfe_feature_scheduler;
    import tfe_pkg::*;

    localparam int BL_A  = 4;
    localparam int LAT_A = 3;
    localparam int BL_B  = 1;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0;
    logic [FEAT_W-1:0] f0 = '0, f1 = '0;

    always #5 clk = ~clk;

    tfe_feature_scheduler_if ifa ();
    tfe_feature_scheduler_if ifb ();

    assign ifa.i_req0_valid   = v0;
    assign ifa.i_req1_valid   = v1;
    assign ifa.i_req0_feature = f0;
    assign ifa.i_req1_feature = f1;
    assign ifb.i_req0_valid   = v0;
    assign ifb.i_req1_valid   = v1;
    assign ifb.i_req0_feature = f0;
    assign ifb.i_req1_feature = f1;

    logic [FEAT_W-1:0] a_feature, b_feature;
    logic a_fv, a_src, a_last, a_busy, a_done;
    logic b_fv, b_src, b_last, b_busy, b_done;

    tfe_feature_scheduler #(.BURST_LEN(BL_A), .PP_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .req_if(ifa),
        .o_feature(a_feature), .o_feature_valid(a_fv), .o_pp_src(a_src),
        .o_pp_last(a_last), .o_busy(a_busy), .o_burst_done(a_done)
    );

    tfe_feature_scheduler #(.BURST_LEN(BL_B), .PP_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .req_if(ifb),
        .o_feature(b_feature), .o_feature_valid(b_fv), .o_pp_src(b_src),
        .o_pp_last(b_last), .o_busy(b_busy), .o_burst_done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts words of the open burst; history[j] is the tag issued j cycles ago.
    int                bl_of [2] = '{BL_A, BL_B};
    int                lat_of[2] = '{LAT_A, LAT_B};
    logic              m_busy [2] = '{1'b0, 1'b0};
    logic              m_owner[2] = '{1'b0, 1'b0};
    logic              m_ptr  [2] = '{1'b0, 1'b0};
    logic              m_done [2] = '{1'b0, 1'b0};
    logic              m_fv   [2] = '{1'b0, 1'b0};
    int                m_words[2] = '{0, 0};
    logic [FEAT_W-1:0] m_feat [2];
    logic [1:0]        m_hist [2][5];
    logic              mx, ml;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 1'b0; m_ptr[k] = 1'b0; m_done[k] = 1'b0;
                m_fv[k] = 1'b0; m_words[k] = 0; m_feat[k] = '0;
                for (int j = 0; j < 5; j++) m_hist[k][j] = 2'b00;
            end else begin
                mx = 1'b0; ml = 1'b0; m_done[k] = 1'b0;
                if (m_busy[k]) begin
                    if (flush) begin
                        m_busy[k] = 1'b0; m_words[k] = 0;
                    end else if (m_owner[k] ? v1 : v0) begin
                        mx = 1'b1;
                        m_feat[k] = m_owner[k] ? f1 : f0;
                        m_words[k] = m_words[k] + 1;
                        if (m_words[k] == bl_of[k]) begin
                            ml = 1'b1; m_busy[k] = 1'b0; m_words[k] = 0;
                            m_ptr[k] = !m_owner[k]; m_done[k] = 1'b1;
                        end
                    end
                end else if (!flush && (v0 || v1)) begin
                    m_busy[k] = 1'b1;
                    m_owner[k] = (v0 && v1) ? m_ptr[k] : v1;
                end
                m_fv[k] = mx;
                for (int j = 4; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = {mx & m_owner[k], ml};
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; flush = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
        f0 = {FEAT_W{1'b1}}; f1 = {FEAT_W{1'b1}};
        tick; tick;
        #1;
        n_checks++;
        if ({a_feature, a_fv, a_src, a_last, a_busy, a_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {a_feature, a_fv, a_src, a_last, a_busy, a_done});
        end
        n_checks++;
        if ({ifa.o_req0_ready, ifa.o_req1_ready, dut_a.cnt_q, dut_a.ptr_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_ready_cnt_ptr: got %h expected 0", {ifa.o_req0_ready, ifa.o_req1_ready, dut_a.cnt_q, dut_a.ptr_q});
        end
        v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        int grants[$]; int xt[$]; int fv_t[$]; int last_t[$]; int done_n;
        int exp_g[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        done_n = 0;
        do_reset;
        v0 = 1'b1; v1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (a_fv) fv_t.push_back(c);
            if (a_last) last_t.push_back(c);
            if (a_done) done_n++;
            if (grants.size() == 8) begin v0 = 1'b0; v1 = 1'b0; end
            if (ifa.o_req0_ready && v0) begin grants.push_back(0); xt.push_back(c); end
            else if (ifa.o_req1_ready && v1) begin grants.push_back(1); xt.push_back(c); end
            tick;
        end
        n_checks++;
        if (grants.size() != 8) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d expected 8", grants.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (grants[i] != exp_g[i]) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, grants[i], exp_g[i]);
                end
            end
            n_checks++;
            if (xt[4] - xt[3] != 2 || xt[3] - xt[0] != 3) begin
                n_fail++;
                $display("FAIL rr_idle_gap: got gap %0d span %0d expected 2 and 3", xt[4] - xt[3], xt[3] - xt[0]);
            end
        end
        n_checks++;
        if (done_n != 2) begin
            n_fail++;
            $display("FAIL rr_done_pulses: got %0d expected 2", done_n);
        end
        n_checks++;
        if (fv_t.size() != 8 || last_t.size() != 2) begin
            n_fail++;
            $display("FAIL rr_out_counts: got fv=%0d last=%0d expected 8 and 2", fv_t.size(), last_t.size());
        end else begin
            n_checks++;
            if (last_t[0] != fv_t[3] + LAT_A || last_t[1] != fv_t[7] + LAT_A) begin
                n_fail++;
                $display("FAIL rr_pp_last_align: got %0d,%0d expected %0d,%0d", last_t[0], last_t[1], fv_t[3] + LAT_A, fv_t[7] + LAT_A);
            end
        end
    endtask

    task automatic test_single_requester;
        int n; logic r0_seen;
        n = 0; r0_seen = 1'b0;
        do_reset;
        v1 = 1'b1;
        tick;
        n_checks++;
        if ({ifa.o_req0_ready, ifa.o_req1_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant_immediate: got %b expected 01", {ifa.o_req0_ready, ifa.o_req1_ready});
        end
        for (int c = 0; c < 10; c++) begin
            v1 = (n < 4);
            if (ifa.o_req0_ready) r0_seen = 1'b1;
            if (ifa.o_req1_ready && v1) n++;
            tick;
        end
        n_checks++;
        if (n != 4 || r0_seen || dut_a.ptr_q !== 1'b0) begin
            n_fail++;
            $display("FAIL single_burst_ptr: got n=%0d r0=%b ptr=%b expected 4 0 0", n, r0_seen, dut_a.ptr_q);
        end
    endtask

    task automatic test_stall;
        int n; int stall; int done_n; int fv_t[$];
        n = 0; stall = 0; done_n = 0;
        do_reset;
        for (int c = 0; c < 20; c++) begin
            if (a_fv) fv_t.push_back(c);
            if (a_done) done_n++;
            if (n == 2 && stall < 3) begin
                v0 = 1'b0;
                stall++;
                if (stall == 3) begin
                    n_checks++;
                    if (dut_a.cnt_q !== 8'd2 || a_busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_cnt_hold: got cnt=%0d busy=%b expected 2 1", dut_a.cnt_q, a_busy);
                    end
                end
            end else begin
                v0 = (n < 4);
            end
            if (v0 && ifa.o_req0_ready) n++;
            tick;
        end
        n_checks++;
        if (n != 4 || done_n != 1 || fv_t.size() != 4) begin
            n_fail++;
            $display("FAIL stall_totals: got xfers=%0d done=%0d fv=%0d expected 4 1 4", n, done_n, fv_t.size());
        end else begin
            n_checks++;
            if (fv_t[2] - fv_t[1] != 4) begin
                n_fail++;
                $display("FAIL stall_fv_gap: got %0d expected 4", fv_t[2] - fv_t[1]);
            end
        end
    endtask

    task automatic test_flush;
        int n; int guard; int fvn; int lastn; int donen;
        n = 0; guard = 0; fvn = 0; lastn = 0; donen = 0;
        do_reset;
        v0 = 1'b1; v1 = 1'b1;
        while (n < 2 && guard < 20) begin
            if (a_fv) fvn++;
            if (ifa.o_req0_ready || ifa.o_req1_ready) n++;
            tick;
            guard++;
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if ({ifa.o_req0_ready, ifa.o_req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_ready_low: got %b expected 00", {ifa.o_req0_ready, ifa.o_req1_ready});
        end
        for (int i = 0; i < 8; i++) begin
            if (a_fv) fvn++;
            if (a_last) lastn++;
            if (a_done) donen++;
            tick;
            if (i == 0) begin
                flush = 1'b0; v0 = 1'b0; v1 = 1'b0;
                n_checks++;
                if (a_busy !== 1'b0 || dut_a.cnt_q !== 8'd0) begin
                    n_fail++;
                    $display("FAIL flush_to_idle: got busy=%b cnt=%0d expected 0 0", a_busy, dut_a.cnt_q);
                end
            end
        end
        n_checks++;
        if (fvn != 2 || lastn != 0 || donen != 0) begin
            n_fail++;
            $display("FAIL flush_drain: got fv=%0d last=%0d done=%0d expected 2 0 0", fvn, lastn, donen);
        end
        v0 = 1'b1; v1 = 1'b1;
        tick;
        n_checks++;
        if ({ifa.o_req0_ready, ifa.o_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_same_requester: got %b expected 10", {ifa.o_req0_ready, ifa.o_req1_ready});
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        int n; int guard; int seen;
        n = 0; guard = 0; seen = 0;
        do_reset;
        v0 = 1'b1;
        while (n < 6 && guard < 30) begin
            if (ifa.o_req0_ready) n++;
            tick;
            guard++;
        end
        rst_n = 1'b0;
        tick;
        n_checks++;
        if ({a_feature, a_fv, a_src, a_last, a_busy, a_done, ifa.o_req0_ready, dut_a.cnt_q, dut_a.ptr_q} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h expected 0", {a_feature, a_fv, a_src, a_last, a_busy, a_done, ifa.o_req0_ready, dut_a.cnt_q, dut_a.ptr_q});
        end
        rst_n = 1'b1; v0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (a_fv || a_last || a_done || a_src) seen++;
            tick;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_no_pulse: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_pp_latency;
        int n; int fv_t[$]; int src_t[$];
        n = 0;
        do_reset;
        for (int c = 0; c < 16; c++) begin
            if (a_fv) fv_t.push_back(c);
            if (a_src) src_t.push_back(c);
            v1 = (n < 4);
            if (ifa.o_req1_ready && v1) n++;
            tick;
        end
        n_checks++;
        if (fv_t.size() != 4 || src_t.size() != 4) begin
            n_fail++;
            $display("FAIL pplat_counts: got fv=%0d src=%0d expected 4 4", fv_t.size(), src_t.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (src_t[i] - fv_t[i] != LAT_A) begin
                    n_fail++;
                    $display("FAIL pplat_align[%0d]: got %0d expected %0d", i, src_t[i] - fv_t[i], LAT_A);
                end
            end
        end
    endtask

    task automatic test_burst_len1;
        int xt[$]; int fv_t[$]; int last_t[$]; int done_n; int bad;
        done_n = 0; bad = 0;
        do_reset;
        for (int c = 0; c < 22; c++) begin
            if (b_fv) fv_t.push_back(c);
            if (b_last) last_t.push_back(c);
            if (b_done) done_n++;
            v0 = (c < 16);
            if (ifb.o_req0_ready && v0) xt.push_back(c);
            tick;
        end
        for (int i = 1; i < xt.size(); i++) if (xt[i] - xt[i-1] != 2) bad++;
        n_checks++;
        if (xt.size() != 8 || bad != 0 || done_n != 8) begin
            n_fail++;
            $display("FAIL bl1_bursts: got xfers=%0d bad_gaps=%0d done=%0d expected 8 0 8", xt.size(), bad, done_n);
        end
        n_checks++;
        if (last_t.size() != fv_t.size() || fv_t.size() != 8) begin
            n_fail++;
            $display("FAIL bl1_last_count: got last=%0d fv=%0d expected 8 8", last_t.size(), fv_t.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 8; i++) if (last_t[i] != fv_t[i] + LAT_B) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL bl1_last_align: got %0d misaligned expected 0", bad);
            end
        end
    endtask

    task automatic test_random;
        int errs;
        logic [FEAT_W+4:0] got, exp;
        logic [1:0] hr;
        errs = 0;
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            hr = m_hist[0][LAT_A];
            got = {a_feature, a_fv, a_src, a_last, a_busy, a_done};
            exp = {m_feat[0], m_fv[0], hr[1], hr[0], m_busy[0], m_done[0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                if (errs < 10) $display("FAIL rand_a_out cyc %0d: got %h expected %h", c, got, exp);
                errs++;
            end
            hr = m_hist[1][LAT_B];
            got = {b_feature, b_fv, b_src, b_last, b_busy, b_done};
            exp = {m_feat[1], m_fv[1], hr[1], hr[0], m_busy[1], m_done[1]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                if (errs < 10) $display("FAIL rand_b_out cyc %0d: got %h expected %h", c, got, exp);
                errs++;
            end
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int w = 0; w < 8; w++) begin
                f0[w*32 +: 32] = $urandom();
                f1[w*32 +: 32] = $urandom();
            end
            #1;
            n_checks++;
            if ({ifa.o_req0_ready, ifa.o_req1_ready, ifb.o_req0_ready, ifb.o_req1_ready} !==
                {m_busy[0] && !m_owner[0] && !flush, m_busy[0] && m_owner[0] && !flush,
                 m_busy[1] && !m_owner[1] && !flush, m_busy[1] && m_owner[1] && !flush}) begin
                n_fail++;
                if (errs < 10) $display("FAIL rand_ready cyc %0d: got %b", c, {ifa.o_req0_ready, ifa.o_req1_ready, ifb.o_req0_ready, ifb.o_req1_ready});
                errs++;
            end
            @(posedge clk);
            #1;
        end
        v0 = 1'b0; v1 = 1'b0; flush = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_requester;
        test_stall;
        test_flush;
        test_reset_mid_burst;
        test_pp_latency;
        test_burst_len1;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
